// File: rtl/z_result_stage.sv
// Z result stage: captures single-cycle ALU results or runs an
// iterative unsigned restoring divide into the Z register pair.
module z_result_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             op_div,
   input  logic [WIDTH-1:0] comb_result,
   input  logic [WIDTH-1:0] comb_result_hi,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] z_hi,
   output logic [WIDTH-1:0] z_lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      S_IDLE,
      S_DIV
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] dvs;
   logic [CW-1:0]    cnt;
   logic             acc;
   logic             cap;
   logic             dz;
   logic             dgo;
   logic             last;
   logic [WIDTH-1:0] rsh;
   logic [WIDTH-1:0] r_nx;
   logic [WIDTH-1:0] q_nx;
   logic [WIDTH:0]   t;

   assign acc  = start && (state == S_IDLE);
   assign cap  = acc && !op_div;
   assign dz   = acc && op_div && (divisor == '0);
   assign dgo  = acc && op_div && (divisor != '0);
   assign last = busy && (cnt == CW'(WIDTH - 1));

   // state register
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) state <= S_IDLE;
      else        state <= state_nx;
   end

   // next-state: leave IDLE only for a real divide, return after last step
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (dgo)  state_nx = S_DIV;
         S_DIV:   if (last) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      busy = (state == S_DIV);
   end

   // one restoring step: shift in next dividend bit, try subtract
   always_comb begin
      rsh  = {r[WIDTH-2:0], q[WIDTH-1]};
      t    = {1'b0, rsh} - {1'b0, dvs};
      r_nx = t[WIDTH] ? rsh : t[WIDTH-1:0];
      q_nx = {q[WIDTH-2:0], ~t[WIDTH]};
   end

   // divider working registers, operands latched at start
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         q   <= '0;
         r   <= '0;
         dvs <= '0;
         cnt <= '0;
      end else if (dgo) begin
         q   <= dividend;
         r   <= '0;
         dvs <= divisor;
         cnt <= '0;
      end else if (busy) begin
         q   <= q_nx;
         r   <= r_nx;
         cnt <= cnt + CW'(1);
      end
   end

   // Z pair, sticky divide-by-zero flag and completion pulse
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         z_lo        <= '0;
         z_hi        <= '0;
         div_by_zero <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= cap || dz || last;
         if (cap) begin
            z_lo        <= comb_result;
            z_hi        <= comb_result_hi;
            div_by_zero <= 1'b0;
         end else if (dz) begin
            z_lo        <= '1;
            z_hi        <= dividend;
            div_by_zero <= 1'b1;
         end else if (dgo) begin
            div_by_zero <= 1'b0;
         end else if (last) begin
            z_lo <= q_nx;
            z_hi <= r_nx;
         end
      end
   end

endmodule

// File: tb/tb_z_result_stage.sv
// Self-checking bench for z_result_stage: vector table,
// hand-written corner sequences and randomized ops vs a model.
module tb_z_result_stage;

   logic        clk;
   logic        clear;
   logic        start;
   logic        op_div;
   logic [31:0] comb_result;
   logic [31:0] comb_result_hi;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] z_hi;
   logic [31:0] z_lo;

   int          total;
   int          bad;
   logic [31:0] mlo;
   logic [31:0] mhi;

   z_result_stage #(.WIDTH(32)) dut (
      .clock          (clk),
      .clear          (clear),
      .start          (start),
      .op_div         (op_div),
      .comb_result    (comb_result),
      .comb_result_hi (comb_result_hi),
      .dividend       (dividend),
      .divisor        (divisor),
      .busy           (busy),
      .done           (done),
      .div_by_zero    (div_by_zero),
      .z_hi           (z_hi),
      .z_lo           (z_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        dv;
      logic [31:0] cr;
      logic [31:0] crh;
      logic [31:0] dd;
      logic [31:0] ds;
      logic [31:0] elo;
      logic [31:0] ehi;
      logic        edbz;
      int          elat;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string n, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", n, got, exp);
      end
   endtask

   // start one op, wait for done (bounded), check latency/busy/Z/flag
   task automatic run(input string n, input logic dv,
                      input logic [31:0] cr, input logic [31:0] crh,
                      input logic [31:0] dd, input logic [31:0] ds,
                      input logic [31:0] elo, input logic [31:0] ehi,
                      input logic edbz, input int elat);
      int   lat;
      int   bc;
      logic held;
      @(negedge clk);
      start          = 1'b1;
      op_div         = dv;
      comb_result    = cr;
      comb_result_hi = crh;
      dividend       = dd;
      divisor        = ds;
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      bc    = 0;
      held  = 1'b1;
      while (!done && lat < 100) begin
         if (busy) bc++;
         if (z_lo !== mlo || z_hi !== mhi) held = 1'b0;
         dividend       = $urandom;
         divisor        = $urandom;
         comb_result    = $urandom;
         comb_result_hi = $urandom;
         @(negedge clk);
         lat++;
      end
      chk({n, " latency"}, 64'(lat), 64'(elat));
      chk({n, " busy cycles"}, 64'(bc), 64'(elat - 1));
      if (elat > 1) chk({n, " z held"}, 64'(held), 64'd1);
      chk({n, " z_lo"}, 64'(z_lo), 64'(elo));
      chk({n, " z_hi"}, 64'(z_hi), 64'(ehi));
      chk({n, " dbz"}, 64'(div_by_zero), 64'(edbz));
      mlo = elo;
      mhi = ehi;
      @(negedge clk);
      chk({n, " done pulse width"}, {62'd0, done, busy}, 64'd0);
   endtask

   initial begin
      int          pulses;
      int          at;
      int          kind;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] ch;
      total          = 0;
      bad            = 0;
      mlo            = '0;
      mhi            = '0;
      start          = 1'b0;
      op_div         = 1'b0;
      comb_result    = '0;
      comb_result_hi = '0;
      dividend       = '0;
      divisor        = '0;
      clear          = 1'b0;

      vecs[0] = '{"capture", 1'b0, 32'h8000_0001, 32'h0, 32'h0, 32'h0,
                  32'h8000_0001, 32'h0, 1'b0, 1};
      vecs[1] = '{"div 100/7", 1'b1, 32'h0, 32'h0, 32'd100, 32'd7,
                  32'd14, 32'd2, 1'b0, 33};
      vecs[2] = '{"div max/1", 1'b1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd1,
                  32'hFFFF_FFFF, 32'd0, 1'b0, 33};
      vecs[3] = '{"div 5/9", 1'b1, 32'h0, 32'h0, 32'd5, 32'd9,
                  32'd0, 32'd5, 1'b0, 33};
      vecs[4] = '{"div max/max", 1'b1, 32'h0, 32'h0, 32'hFFFF_FFFF,
                  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33};
      vecs[5] = '{"div by zero", 1'b1, 32'h0, 32'h0, 32'h1234, 32'd0,
                  32'hFFFF_FFFF, 32'h1234, 1'b1, 1};
      vecs[6] = '{"capture clears dbz", 1'b0, 32'h0000_0055,
                  32'hA5A5_0000, 32'h0, 32'h0,
                  32'h0000_0055, 32'hA5A5_0000, 1'b0, 1};
      vecs[7] = '{"div top-bit divisor", 1'b1, 32'h0, 32'h0,
                  32'hFFFF_FFFE, 32'h8000_0001,
                  32'd1, 32'h7FFF_FFFD, 1'b0, 33};

      // reset state
      #12;
      chk("reset outputs", {27'd0, busy, done, div_by_zero, 2'b0, z_hi},
          64'd0);
      chk("reset z_lo", 64'(z_lo), 64'd0);
      @(negedge clk);
      clear = 1'b1;

      for (int i = 0; i < 8; i++)
         run(vecs[i].name, vecs[i].dv, vecs[i].cr, vecs[i].crh,
             vecs[i].dd, vecs[i].ds, vecs[i].elo, vecs[i].ehi,
             vecs[i].edbz, vecs[i].elat);

      // start while busy is ignored, operand changes have no effect
      @(negedge clk);
      start    = 1'b1;
      op_div   = 1'b1;
      dividend = 32'd100;
      divisor  = 32'd7;
      @(negedge clk);
      start  = 1'b0;
      pulses = 0;
      at     = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (done) begin
            pulses++;
            if (at == 0) at = cyc;
         end
         start = (cyc == 10);
         if (cyc == 10) begin
            op_div      = 1'b0;
            comb_result = 32'hDEAD;
         end
         if (cyc == 12) divisor = 32'd3;
         @(negedge clk);
      end
      chk("busy prot pulses", 64'(pulses), 64'd1);
      chk("busy prot latency", 64'(at), 64'd33);
      chk("busy prot z", {z_hi, z_lo}, {32'd2, 32'd14});
      mlo = 32'd14;
      mhi = 32'd2;

      // back-to-back: capture, capture, then a divide on a done cycle
      @(negedge clk);
      start          = 1'b1;
      op_div         = 1'b0;
      comb_result    = 32'h1111_0000;
      comb_result_hi = 32'h2222;
      @(negedge clk);
      chk("b2b first", {31'd0, done, z_lo}, {31'd1, 32'h1111_0000});
      comb_result    = 32'h3333_0000;
      comb_result_hi = 32'h4444;
      @(negedge clk);
      chk("b2b second", {31'd0, done, z_hi}, {31'd1, 32'h4444});
      op_div   = 1'b1;
      dividend = 32'd1000;
      divisor  = 32'd33;
      @(negedge clk);
      start = 1'b0;
      at    = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (done && at == 0) at = cyc;
         @(negedge clk);
      end
      chk("b2b div latency", 64'(at), 64'd33);
      chk("b2b div z", {z_hi, z_lo}, {32'd10, 32'd30});
      mlo = 32'd30;
      mhi = 32'd10;

      // asynchronous reset in the middle of a divide
      @(negedge clk);
      start    = 1'b1;
      op_div   = 1'b1;
      dividend = 32'd100;
      divisor  = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      #2 clear = 1'b0;
      #1;
      chk("mid reset flags", {61'd0, busy, done, div_by_zero}, 64'd0);
      chk("mid reset z", {z_hi, z_lo}, 64'd0);
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) pulses++;
      end
      clear = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      chk("mid reset no done", 64'(pulses), 64'd0);
      mlo = '0;
      mhi = '0;
      run("after reset 100/7", 1'b1, 32'h0, 32'h0, 32'd100, 32'd7,
          32'd14, 32'd2, 1'b0, 33);

      // randomized ops against an arithmetic model
      for (int k = 0; k < 40; k++) begin
         kind = int'($urandom_range(0, 9));
         a    = $urandom;
         b    = $urandom;
         c    = $urandom;
         ch   = $urandom;
         if (kind == 3) a = $urandom_range(0, 1000);
         if (kind < 6 && kind > 2) b = $urandom_range(1, 300);
         if (kind == 2) b = 32'd0;
         if (kind < 2)
            run("rand capture", 1'b0, c, ch, a, b, c, ch, 1'b0, 1);
         else if (b == 32'd0)
            run("rand div0", 1'b1, c, ch, a, b, 32'hFFFF_FFFF, a, 1'b1, 1);
         else
            run("rand div", 1'b1, c, ch, a, b, a / b, a % b, 1'b0, 33);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
